// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM encoding, GF(2^8) arithmetic, forward/inverse S-box, Rcon.
// S-boxes are computed arithmetically (field inverse plus affine map) rather than tabulated.
package aes_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYEXP = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DONE   = 2'd3
    } aes_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            p  = b[i] ? (p ^ aa) : p;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8); maps 0 to 0 as the S-box requires
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] acc;
        p   = x;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gmul(p, p);
            acc = gmul(acc, p);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return ginv(b);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the final round. Byte 0 of the state is bits [127:120].
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] key_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    logic [127:0] sub_s;
    logic [127:0] keyed_s;
    logic [127:0] mix_s;

    // Row r rotates right by r columns; byte index is 4*col + row
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int DST = 4 * c + r;
            localparam int SRC = 4 * ((c - r + 4) % 4) + r;
            assign sub_s[127 - 8 * DST -: 8] = inv_sbox(state_i[127 - 8 * SRC -: 8]);
        end
        assign mix_s[127 - 32 * c -: 32] = inv_mix_col(keyed_s[127 - 32 * c -: 32]);
    end

    assign keyed_s = sub_s ^ key_i;
    assign state_o = last_i ? keyed_s : mix_s;

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor, one inverse round per clock, round keys unrolled backwards on the fly.
// Define AES_DEC_FWD_KEY_EN to accept the cipher key and expand it forward to K10 first.
module aes_decrypt_iter
    import aes_pkg::*;
#(
    parameter int BLOCK_W    = 128,
    parameter int NUM_ROUNDS = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic [BLOCK_W-1:0] in_key,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               busy
);

    // Recovers K(r-1) from K(r)
    function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w0, w1, w2, w3, n0, n1, n2, n3;
        {w0, w1, w2, w3} = k;
        n3 = w3 ^ w2;
        n2 = w2 ^ w1;
        n1 = w1 ^ w0;
        n0 = w0 ^ sub_word(rot_word(n3)) ^ {rcon(r), 24'h000000};
        return {n0, n1, n2, n3};
    endfunction

`ifdef AES_DEC_FWD_KEY_EN
    function automatic logic [127:0] fwd_key_step(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w0, w1, w2, w3, n0, n1, n2, n3;
        {w0, w1, w2, w3} = k;
        n0 = w0 ^ sub_word(rot_word(w3)) ^ {rcon(r), 24'h000000};
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction
`endif

    aes_state_e         fsm_q, fsm_d;
    logic [127:0]       blk_q, blk_d;
    logic [127:0]       key_q, key_d;
    logic [3:0]         rnd_q, rnd_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [BLOCK_W-1:0] out_data_q, out_data_d;
    logic               busy_q, busy_d;

    logic [127:0]       rnd_key_s;
    logic [127:0]       round_out_s;

    assign rnd_key_s = inv_key_step(key_q, rnd_q + 4'd1);

`ifdef AES_DEC_FWD_KEY_EN
    logic [127:0] fwd_key_s;
    assign fwd_key_s = fwd_key_step(key_q, rnd_q);
`endif

    aes_inv_round u_inv_round (
        .state_i (blk_q),
        .key_i   (rnd_key_s),
        .last_i  (rnd_q == 4'd0),
        .state_o (round_out_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= ST_IDLE;
            blk_q       <= 128'd0;
            key_q       <= 128'd0;
            rnd_q       <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= {BLOCK_W{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            blk_q       <= blk_d;
            key_q       <= key_d;
            rnd_q       <= rnd_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, datapath and round counter
    always_comb begin
        fsm_d = fsm_q;
        blk_d = blk_q;
        key_d = key_q;
        rnd_d = rnd_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
`ifdef AES_DEC_FWD_KEY_EN
                    blk_d = in_data;
                    key_d = in_key;
                    rnd_d = 4'd1;
                    fsm_d = ST_KEYEXP;
`else
                    blk_d = in_data ^ in_key;
                    key_d = in_key;
                    rnd_d = 4'(NUM_ROUNDS - 1);
                    fsm_d = ST_ROUND;
`endif
                end else begin
                    fsm_d = ST_IDLE;
                end
            end
            ST_KEYEXP: begin
`ifdef AES_DEC_FWD_KEY_EN
                key_d = fwd_key_s;
                if (rnd_q == 4'(NUM_ROUNDS)) begin
                    blk_d = blk_q ^ fwd_key_s;
                    rnd_d = 4'(NUM_ROUNDS - 1);
                    fsm_d = ST_ROUND;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
`else
                fsm_d = ST_IDLE;
`endif
            end
            ST_ROUND: begin
                blk_d = round_out_s;
                key_d = rnd_key_s;
                if (rnd_q == 4'd0) begin
                    fsm_d = ST_DONE;
                end else begin
                    rnd_d = rnd_q - 4'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end else begin
                    fsm_d = ST_DONE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the FSM
    always_comb begin
        in_ready_d  = (fsm_d == ST_IDLE);
        out_valid_d = (fsm_d == ST_DONE);
        busy_d      = (fsm_d != ST_IDLE);
        out_data_d  = (fsm_d == ST_DONE) ? blk_d : {BLOCK_W{1'b0}};
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter using FIPS-197 vectors; honours AES_DEC_FWD_KEY_EN.
module tb_aes_decrypt_iter;

`ifdef AES_DEC_FWD_KEY_EN
    localparam int           LAT  = 21;
    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
`else
    localparam int           LAT  = 11;
    localparam logic [127:0] KEY1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY2 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
`endif
    localparam logic [127:0] CT1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aes_decrypt_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one block for a single accept edge, then scrambles the inputs
    task automatic send(input logic [127:0] ct, input logic [127:0] key);
        in_valid = 1'b1;
        in_data  = ct;
        in_key   = key;
        step();
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_key   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Sends a block and checks latency and result; ends in the first out_valid cycle
    task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] key,
                             input logic [127:0] pt);
        send(ct, key);
        chk({tag, "_busy_c1"}, {127'd0, busy}, 128'd1);
        chk({tag, "_rdy_c1"}, {127'd0, in_ready}, 128'd0);
        repeat (LAT - 2) step();
        chk({tag, "_vld_early"}, {127'd0, out_valid}, 128'd0);
        step();
        chk({tag, "_vld"}, {127'd0, out_valid}, 128'd1);
        chk({tag, "_data"}, out_data, pt);
        chk({tag, "_rdy_done"}, {127'd0, in_ready}, 128'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 128'd0;
        in_key    = 128'd0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);

        // Vectors 1 and 2 with the sink always ready
        out_ready = 1'b1;
        run_block("v1", CT1, KEY1, PT1);
        step();
        chk("v1_idle_rdy", {127'd0, in_ready}, 128'd1);
        chk("v1_idle_vld", {127'd0, out_valid}, 128'd0);
        chk("v1_idle_busy", {127'd0, busy}, 128'd0);
        run_block("v2", CT2, KEY2, PT2);
        step();
        chk("v2_idle_rdy", {127'd0, in_ready}, 128'd1);

        // Backpressure, then both handshakes offered together in DONE
        out_ready = 1'b0;
        run_block("bp", CT1, KEY1, PT1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_vld", {127'd0, out_valid}, 128'd1);
            chk("bp_hold_data", out_data, PT1);
            chk("bp_hold_rdy", {127'd0, in_ready}, 128'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = CT2;
        in_key    = KEY2;
        step();
        in_valid = 1'b0;
        chk("bp_rel_rdy", {127'd0, in_ready}, 128'd1);
        chk("bp_rel_vld", {127'd0, out_valid}, 128'd0);
        chk("bp_rel_busy", {127'd0, busy}, 128'd0);

        // Garbage in_valid activity while busy must be ignored
        send(CT1, KEY1);
        for (int i = 1; i < LAT; i++) begin
            in_valid = i[0];
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_key   = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        in_valid = 1'b0;
        chk("gb_vld", {127'd0, out_valid}, 128'd1);
        chk("gb_data", out_data, PT1);
        step();

        // Reset in cycle 5 of a block abandons it
        send(CT2, KEY2);
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_vld", {127'd0, out_valid}, 128'd0);
        chk("mr_data", out_data, 128'd0);
        chk("mr_rdy", {127'd0, in_ready}, 128'd1);
        chk("mr_busy", {127'd0, busy}, 128'd0);
        run_block("mr_next", CT1, KEY1, PT1);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
